// File: rtl/main_fsm_pkg.sv
// ============================================================================
// Module      : main_fsm_pkg
// Description : Shared state codes, instruction-class codes and datapath
//               selector constants for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package main_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_EXECUTEF = 4'd10,
      S_FPUWAIT  = 4'd11,
      S_FPUWB    = 4'd12
   } state_t;

   localparam logic [1:0] c_OP_DP     = 2'b00;
   localparam logic [1:0] c_OP_MEM    = 2'b01;
   localparam logic [1:0] c_OP_BRANCH = 2'b10;
   localparam logic [1:0] c_OP_FPU    = 2'b11;

   localparam logic [1:0] c_SRCB_REG  = 2'b00;
   localparam logic [1:0] c_SRCB_IMM  = 2'b01;
   localparam logic [1:0] c_SRCB_FOUR = 2'b10;

   localparam logic [1:0] c_RES_ALUOUT = 2'b00;
   localparam logic [1:0] c_RES_DATA   = 2'b01;
   localparam logic [1:0] c_RES_ALU    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/main_fsm_fpu_watchdog.sv
// ============================================================================
// Module      : fpu_watchdog
// Description : FPUWAIT cycle counter with a sticky timeout error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_watchdog #(
   parameter int FPU_TIMEOUT = 31
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic wait_i,
   input  logic done_i,
   output logic timeout_o,
   output logic err_o
);

   localparam logic [4:0] c_LIMIT = 5'(FPU_TIMEOUT);

   logic [4:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic [4:0] w_cnt_inc;

   assign w_cnt_inc = cnt_q + 5'd1;

   // Timeout fires in the wait cycle whose increment would reach the limit,
   // so the FSM spends at most FPU_TIMEOUT cycles in FPUWAIT.
   assign timeout_o = wait_i && !done_i && (w_cnt_inc == c_LIMIT);
   assign err_o     = err_q;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clear_i) begin
         cnt_d = 5'd0;
      end else if (wait_i && !done_i) begin
         cnt_d = w_cnt_inc;
      end
      if (timeout_o) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 5'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/main_fsm.sv
// ============================================================================
// Module      : main_fsm
// Description : Multicycle processor main control FSM with FPU handshake and
//               watchdog. All control outputs are decoded from State only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm
   import main_fsm_pkg::*;
#(
   parameter int FPU_TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       FPUDone,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       ResSrc,
   output logic       FPUStart,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       FPUErr,
   output logic [3:0] State
);

   state_t state_q, state_d;
   logic   w_timeout;
   logic   w_unused_funct;

   assign w_unused_funct = ^Funct[4:1];
   assign State          = state_q;

   fpu_watchdog #(
      .FPU_TIMEOUT (FPU_TIMEOUT)
   ) u_fpu_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (state_q == S_EXECUTEF),
      .wait_i    (state_q == S_FPUWAIT),
      .done_i    (FPUDone),
      .timeout_o (w_timeout),
      .err_o     (FPUErr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               c_OP_MEM:    state_d = S_MEMADR;
               c_OP_BRANCH: state_d = S_BRANCH;
               c_OP_FPU:    state_d = S_EXECUTEF;
               default:     state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
            endcase
         end
         S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_EXECUTEF: state_d = S_FPUWAIT;
         // Done takes priority over a timeout landing in the same cycle.
         S_FPUWAIT: begin
            if (FPUDone)        state_d = S_FPUWB;
            else if (w_timeout) state_d = S_FETCH;
            else                state_d = S_FPUWAIT;
         end
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      ResSrc    = 1'b0;
      FPUStart  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = c_SRCB_REG;
      ResultSrc = c_RES_ALUOUT;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = c_SRCB_FOUR;
            ResultSrc = c_RES_ALU;
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = c_SRCB_FOUR;
            ResultSrc = c_RES_ALU;
         end
         S_MEMADR:   ALUSrcB = c_SRCB_IMM;
         S_MEMRD:    AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = c_RES_DATA;
            RegW      = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         S_EXECUTER: ALUOp = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = c_SRCB_IMM;
            ALUOp   = 1'b1;
         end
         S_ALUWB:    RegW = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = c_SRCB_IMM;
            ResultSrc = c_RES_ALU;
            Branch    = 1'b1;
         end
         S_EXECUTEF: FPUStart = 1'b1;
         S_FPUWB: begin
            ResSrc = 1'b1;
            RegW   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_main_fsm.sv
// ============================================================================
// Module      : tb_main_fsm
// Description : Directed plus random instruction bench for main_fsm, checked
//               against a per-instruction expected state/output sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_fsm;
   import main_fsm_pkg::*;

   localparam int TO = 31;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic       FPUDone = 1'b0;
   logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, ResSrc, FPUStart;
   logic       ALUSrcA, FPUErr;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] State;
   logic [13:0] outs_obs;

   int   total = 0;
   int   bad = 0;
   logic err_exp = 1'b0;

   main_fsm #(.FPU_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .FPUDone(FPUDone),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW),
      .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .ResSrc(ResSrc),
      .FPUStart(FPUStart), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .FPUErr(FPUErr), .State(State)
   );

   always #5 clk = ~clk;

   assign outs_obs = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
                      ResSrc, FPUStart, ALUSrcA, ALUSrcB, ResultSrc};

   function automatic logic [13:0] exp_outs(state_t s);
      logic irw = 0, adr = 0, npc = 0, rw = 0, mw = 0, br = 0;
      logic aop = 0, rs = 0, fs = 0, sa = 0;
      logic [1:0] sb = 2'b00, res = 2'b00;
      case (s)
         S_FETCH:    begin sa = 1; sb = 2'b10; res = 2'b10; irw = 1; npc = 1; end
         S_DECODE:   begin sa = 1; sb = 2'b10; res = 2'b10; end
         S_MEMADR:   sb = 2'b01;
         S_MEMRD:    adr = 1;
         S_MEMWB:    begin res = 2'b01; rw = 1; end
         S_MEMWR:    begin adr = 1; mw = 1; end
         S_EXECUTER: aop = 1;
         S_EXECUTEI: begin sb = 2'b01; aop = 1; end
         S_ALUWB:    rw = 1;
         S_BRANCH:   begin sb = 2'b01; res = 2'b10; br = 1; end
         S_EXECUTEF: fs = 1;
         S_FPUWB:    begin rs = 1; rw = 1; end
         default: ;
      endcase
      return {irw, adr, npc, rw, mw, br, aop, rs, fs, sa, sb, res};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Entered at a falling edge where FETCH is expected; leaves at the falling
   // edge of the following FETCH (or right after an aborting reset).
   // done_at: FPUWAIT cycle (1-based) that sees FPUDone=1; out of 1..TO means never.
   task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                            input int done_at, input int abort_idx);
      state_t q[$];
      bit     timeout = 0;
      int     w = 0;
      q.push_back(S_FETCH);
      q.push_back(S_DECODE);
      case (op)
         2'b01: begin
            q.push_back(S_MEMADR);
            if (fn[0]) begin q.push_back(S_MEMRD); q.push_back(S_MEMWB); end
            else q.push_back(S_MEMWR);
         end
         2'b00: begin
            q.push_back(fn[5] ? S_EXECUTEI : S_EXECUTER);
            q.push_back(S_ALUWB);
         end
         2'b10: q.push_back(S_BRANCH);
         default: begin
            q.push_back(S_EXECUTEF);
            timeout = !(done_at >= 1 && done_at <= TO);
            for (int k = 0; k < (timeout ? TO : done_at); k++) q.push_back(S_FPUWAIT);
            if (!timeout) q.push_back(S_FPUWB);
         end
      endcase
      Op = op;
      Funct = fn;
      for (int i = 0; i < q.size(); i++) begin
         chk("state", 32'(State), 32'(q[i]));
         chk("outputs", 32'(outs_obs), 32'(exp_outs(q[i])));
         chk("fpuerr", 32'(FPUErr), 32'(err_exp));
         if (q[i] == S_FPUWAIT) begin
            w++;
            FPUDone = (w == done_at);
         end else begin
            FPUDone = 1'($urandom);
         end
         if (i == abort_idx) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            FPUDone = 1'b0;
            err_exp = 1'b0;
            return;
         end
         @(negedge clk);
      end
      if (timeout) err_exp = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      err_exp = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_state", 32'(State), 32'(S_FETCH));
      chk("reset_fpuerr", 32'(FPUErr), 32'd0);

      run_instr(2'b01, 6'b000001, 0, -1);   // load
      run_instr(2'b00, 6'b100000, 0, -1);   // immediate data-processing
      run_instr(2'b00, 6'b000000, 0, -1);   // register data-processing
      run_instr(2'b10, 6'b010101, 0, -1);   // branch
      run_instr(2'b11, 6'b000000, 3, -1);   // FPU, done on 3rd wait
      run_instr(2'b11, 6'b000000, 0, -1);   // FPU timeout
      run_instr(2'b10, 6'b000000, 0, -1);   // error stays sticky
      run_instr(2'b01, 6'b000000, 0, -1);   // store
      do_reset();
      run_instr(2'b11, 6'b000000, TO, -1);  // done wins at the limit
      run_instr(2'b11, 6'b000000, 0, -1);   // timeout again
      run_instr(2'b01, 6'b000000, 0, 3);    // reset while in MEMWR
      run_instr(2'b01, 6'b000001, 0, -1);
      run_instr(2'b11, 6'b000000, 0, 6);    // reset while in FPUWAIT
      run_instr(2'b00, 6'b100000, 0, -1);

      for (int n = 0; n < 40; n++) begin
         run_instr(2'($urandom), 6'($urandom), int'($urandom_range(0, 34)),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
